// File: rtl/mem_access_sequencer_if.sv
// Handshake bundle between the core control unit, the data serialiser and memory.
// The slave view belongs to the sequencer; the master view belongs to its environment.
interface mem_access_sequencer_if;
  logic       start;
  logic       is_store;
  logic [2:0] req_func;
  logic       busy;
  logic       bit_valid;
  logic       ser_mode;
  logic [4:0] ser_bitpos;
  logic [2:0] ser_func;
  logic       addr_bit;
  logic       mem_req;
  logic       mem_we;
  logic [3:0] mem_wstrb;
  logic       mem_ack;
  logic       done;
  logic       fault;
  logic [1:0] fault_cause;

  modport slave (
    input  start, is_store, req_func, addr_bit, mem_ack,
    output busy, bit_valid, ser_mode, ser_bitpos, ser_func,
           mem_req, mem_we, mem_wstrb, done, fault, fault_cause
  );

  modport master (
    output start, is_store, req_func, addr_bit, mem_ack,
    input  busy, bit_valid, ser_mode, ser_bitpos, ser_func,
           mem_req, mem_we, mem_wstrb, done, fault, fault_cause
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences one bit-serial load/store: address shift, legality check, memory
// handshake and data shift, then reports done or fault.
//
// state         | meaning
// --------------+--------------------------------------------------
// S_IDLE        | waiting for start
// S_ADDR        | shifting ADDR_BITS address bits, ser_mode=1
// S_CHECK       | func legality / alignment decision
// S_LOAD_REQ    | mem_req with mem_we=0, waiting for ack or timeout
// S_LOAD_SHIFT  | core samples DATA_BITS read bits
// S_STORE_SHIFT | core drives DATA_BITS write bits
// S_STORE_REQ   | mem_req with mem_we=1, waiting for ack or timeout
// S_DONE        | done pulse
// S_FAULT       | fault pulse, fault_cause loaded
module mem_access_sequencer #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT   = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  mem_access_sequencer_if.slave bus
);
  localparam int         WW        = $clog2(TIMEOUT + 2);
  localparam logic [5:0] ADDR_LAST = 6'(ADDR_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_CHECK, S_LOAD_REQ, S_LOAD_SHIFT,
    S_STORE_SHIFT, S_STORE_REQ, S_DONE, S_FAULT
  } state_t;

  state_t        state;
  logic [5:0]    cnt;
  logic [WW-1:0] wait_cnt;
  logic          is_store_q;
  logic [1:0]    addr_lo;
  logic          illegal;
  logic          misaligned;
  logic [3:0]    strb;

  always_comb begin
    illegal    = (bus.ser_func == 3'b011) || (bus.ser_func == 3'b110) ||
                 (bus.ser_func == 3'b111);
    misaligned = ((bus.ser_func[1:0] == 2'b10) && (addr_lo != 2'b00)) ||
                 ((bus.ser_func[1:0] == 2'b01) && addr_lo[0]);
    case (bus.ser_func[1:0])
      2'b00:   strb = 4'b0001 << addr_lo;
      2'b01:   strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      wait_cnt        <= '0;
      is_store_q      <= 1'b0;
      addr_lo         <= 2'b00;
      bus.busy        <= 1'b0;
      bus.bit_valid   <= 1'b0;
      bus.ser_mode    <= 1'b0;
      bus.ser_bitpos  <= '0;
      bus.ser_func    <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_wstrb   <= '0;
      bus.done        <= 1'b0;
      bus.fault       <= 1'b0;
      bus.fault_cause <= '0;
    end else begin
      bus.done  <= 1'b0;
      bus.fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state           <= S_ADDR;
            is_store_q      <= bus.is_store;
            bus.ser_func    <= bus.req_func;
            bus.fault_cause <= '0;
            bus.busy        <= 1'b1;
            bus.bit_valid   <= 1'b1;
            bus.ser_mode    <= 1'b1;
            bus.ser_bitpos  <= '0;
            cnt             <= '0;
          end
        end
        S_ADDR: begin
          if (cnt == 6'd0) addr_lo[0] <= bus.addr_bit;
          if (cnt == 6'd1) addr_lo[1] <= bus.addr_bit;
          if (cnt == ADDR_LAST) begin
            state          <= S_CHECK;
            bus.bit_valid  <= 1'b0;
            bus.ser_mode   <= 1'b0;
            bus.ser_bitpos <= '0;
          end else begin
            cnt            <= cnt + 6'd1;
            bus.ser_bitpos <= 5'(cnt + 6'd1);
          end
        end
        S_CHECK: begin
          // illegal func must win over misalignment
          if (illegal) begin
            state           <= S_FAULT;
            bus.fault       <= 1'b1;
            bus.fault_cause <= 2'b10;
          end else if (misaligned) begin
            state           <= S_FAULT;
            bus.fault       <= 1'b1;
            bus.fault_cause <= 2'b01;
          end else if (is_store_q) begin
            state          <= S_STORE_SHIFT;
            bus.bit_valid  <= 1'b1;
            bus.ser_bitpos <= '0;
            cnt            <= '0;
          end else begin
            state       <= S_LOAD_REQ;
            bus.mem_req <= 1'b1;
            bus.mem_we  <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        S_LOAD_SHIFT, S_STORE_SHIFT: begin
          if (cnt == DATA_LAST) begin
            bus.bit_valid  <= 1'b0;
            bus.ser_bitpos <= '0;
            if (state == S_LOAD_SHIFT) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
            end else begin
              state         <= S_STORE_REQ;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_wstrb <= strb;
              wait_cnt      <= '0;
            end
          end else begin
            cnt            <= cnt + 6'd1;
            bus.ser_bitpos <= 5'(cnt + 6'd1);
          end
        end
        S_LOAD_REQ, S_STORE_REQ: begin
          if (bus.mem_ack) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wstrb <= '0;
            if (state == S_LOAD_REQ) begin
              state          <= S_LOAD_SHIFT;
              bus.bit_valid  <= 1'b1;
              bus.ser_bitpos <= '0;
              cnt            <= '0;
            end else begin
              state    <= S_DONE;
              bus.done <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (int'(wait_cnt) == TIMEOUT - 1)) begin
            state           <= S_FAULT;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_wstrb   <= '0;
            bus.fault       <= 1'b1;
            bus.fault_cause <= 2'b11;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE, S_FAULT: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed test-plan cases, random accesses
// against a transaction-level model, start-ignore and asynchronous reset.
module tb_mem_access_sequencer;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_sequencer_if bus();
  mem_access_sequencer #(.ADDR_BITS(12), .DATA_BITS(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] cur_addr = '0;

  assign bus.addr_bit = (bus.bit_valid && bus.ser_mode && bus.ser_bitpos < 5'd12)
                        ? cur_addr[bus.ser_bitpos[3:0]] : 1'b0;

  typedef struct {
    int total; int req_n; int addr_n; int data_n;
    bit addr_err; bit data_err; bit busy_err; bit got_done; bit got_fault;
    bit idle1; bit idle2; bit rst_hit; bit timed_out;
    logic [1:0] cause; logic [1:0] cause_after; logic we; logic [3:0] wstrb;
    logic [2:0] ser_func; logic [20:0] rst_vec;
  } obs_t;

  typedef struct {
    int total; int req_n; int data_n; bit is_done;
    logic [1:0] cause; logic [3:0] wstrb;
  } exp_t;

  typedef struct {
    bit st; logic [2:0] f; logic [11:0] a; int lat;
    int total; int req_n; logic [1:0] cause; logic [3:0] wstrb;
  } dir_t;

  function automatic logic [20:0] out_vec();
    return {bus.busy, bus.bit_valid, bus.ser_mode, bus.ser_bitpos, bus.ser_func,
            bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.done, bus.fault, bus.fault_cause};
  endfunction

  // Transaction-level expectation: cycle counts from the start cycle to the pulse, inclusive.
  function automatic exp_t model(bit st, logic [2:0] f, logic [11:0] a, int lat);
    exp_t e;
    int   size;
    bit   tmo;
    e.cause = 2'b00;
    e.wstrb = 4'b0000;
    size    = 1 << f[1:0];
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) e.cause = 2'b10;
    else if ((int'(a) % size) != 0)         e.cause = 2'b01;
    if (e.cause != 2'b00) begin
      e.is_done = 0; e.req_n = 0; e.data_n = 0; e.total = 1 + 12 + 1 + 1;
      return e;
    end
    tmo       = (lat >= TO);
    e.req_n   = tmo ? TO : lat + 1;
    e.data_n  = (st || !tmo) ? 32 : 0;
    e.is_done = !tmo;
    if (tmo) e.cause = 2'b11;
    e.total = 1 + 12 + 1 + e.req_n + e.data_n + 1;
    if (st) e.wstrb = 4'(((1 << size) - 1) << a[1:0]);
    return e;
  endfunction

  task automatic run_txn(input bit st, input logic [2:0] f, input logic [11:0] a,
                         input int lat, input int poke_at, input int rst_at, output obs_t o);
    bit ended;
    o = '{default: 0};
    ended = 0;
    cur_addr = a; bus.is_store = st; bus.req_func = f; bus.mem_ack = 1'b0; bus.start = 1'b1;
    o.total = 1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.is_store = ~st; bus.req_func = ~f;
    o.ser_func = bus.ser_func;
    for (int c = 0; c < 200 && !ended; c++) begin
      o.total++;
      if (!bus.busy) o.busy_err = 1;
      if (bus.bit_valid && bus.ser_mode) begin
        if (bus.ser_bitpos != 5'(o.addr_n)) o.addr_err = 1;
        o.addr_n++;
      end
      if (bus.bit_valid && !bus.ser_mode) begin
        if (bus.ser_bitpos != 5'(o.data_n)) o.data_err = 1;
        o.data_n++;
      end
      if (bus.mem_req) begin
        if (o.req_n == 0) begin o.we = bus.mem_we; o.wstrb = bus.mem_wstrb; end
        bus.mem_ack = (o.req_n == lat);
        o.req_n++;
      end else begin
        bus.mem_ack = 1'b0;
      end
      bus.start = (o.total == poke_at);
      if (rst_at == o.total) begin
        #2 rst_n = 1'b0;
        #1 o.rst_vec = out_vec();
        o.rst_hit = 1; ended = 1;
      end else if (bus.done || bus.fault) begin
        o.got_done = bus.done; o.got_fault = bus.fault; o.cause = bus.fault_cause; ended = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    o.timed_out = !ended;
    bus.mem_ack = 1'b0;
    if (ended && !o.rst_hit) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      o.idle1 = !bus.busy; o.cause_after = bus.fault_cause;
      @(posedge clk); #1;
      o.idle2 = !bus.busy && !bus.mem_req;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.is_store = 1'b0; bus.req_func = 3'b000; bus.mem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_vec() !== 21'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", out_vec()); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_vec() !== 21'd0) begin n_fail++; $display("FAIL idle_after_reset: got %h want 0", out_vec()); end
  endtask

  task automatic test_directed();
    dir_t tbl[10];
    obs_t o;
    tbl[0] = '{0, 3'b010, 12'h104, 2,    50, 3, 2'b00, 4'b0000};
    tbl[1] = '{1, 3'b001, 12'h0A6, 1,    49, 2, 2'b00, 4'b1100};
    tbl[2] = '{1, 3'b000, 12'h003, 0,    48, 1, 2'b00, 4'b1000};
    tbl[3] = '{0, 3'b010, 12'h102, 0,    15, 0, 2'b01, 4'b0000};
    tbl[4] = '{0, 3'b011, 12'h000, 0,    15, 0, 2'b10, 4'b0000};
    tbl[5] = '{0, 3'b111, 12'h001, 0,    15, 0, 2'b10, 4'b0000};
    tbl[6] = '{0, 3'b010, 12'h100, 1000, 19, 4, 2'b11, 4'b0000};
    tbl[7] = '{0, 3'b010, 12'h100, 3,    51, 4, 2'b00, 4'b0000};
    tbl[8] = '{1, 3'b010, 12'h008, 1000, 51, 4, 2'b11, 4'b1111};
    tbl[9] = '{1, 3'b000, 12'h001, 2,    50, 3, 2'b00, 4'b0010};
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].st, tbl[i].f, tbl[i].a, tbl[i].lat, 0, 0, o);
      n_checks++;
      if (o.total !== tbl[i].total) begin n_fail++;
        $display("FAIL dir%0d_cycles: got %0d want %0d", i, o.total, tbl[i].total); end
      n_checks++;
      if (o.got_done !== (tbl[i].cause == 2'b00) || o.got_fault !== (tbl[i].cause != 2'b00)) begin n_fail++;
        $display("FAIL dir%0d_outcome: got done=%0d fault=%0d want cause %0d", i, o.got_done, o.got_fault, tbl[i].cause); end
      n_checks++;
      if (o.cause !== tbl[i].cause || o.cause_after !== tbl[i].cause) begin n_fail++;
        $display("FAIL dir%0d_cause: got %0d held %0d want %0d", i, o.cause, o.cause_after, tbl[i].cause); end
      n_checks++;
      if (o.req_n !== tbl[i].req_n) begin n_fail++;
        $display("FAIL dir%0d_req_cycles: got %0d want %0d", i, o.req_n, tbl[i].req_n); end
      n_checks++;
      if (o.addr_n !== 12 || o.addr_err || o.data_err || o.busy_err) begin n_fail++;
        $display("FAIL dir%0d_phases: got addr_n=%0d aerr=%0d derr=%0d berr=%0d want 12 0 0 0",
                 i, o.addr_n, o.addr_err, o.data_err, o.busy_err); end
      n_checks++;
      if (!o.idle1 || !o.idle2) begin n_fail++;
        $display("FAIL dir%0d_idle: got %0d%0d want 11", i, o.idle1, o.idle2); end
      if (tbl[i].req_n > 0) begin
        n_checks++;
        if (o.we !== tbl[i].st || (tbl[i].st && o.wstrb !== tbl[i].wstrb)) begin n_fail++;
          $display("FAIL dir%0d_we_strb: got we=%0d strb=%b want we=%0d strb=%b",
                   i, o.we, o.wstrb, tbl[i].st, tbl[i].wstrb); end
      end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    bit          st;
    logic [2:0]  f;
    logic [11:0] a;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      st  = 1'($urandom_range(0, 1));
      f   = 3'($urandom_range(0, 7));
      a   = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      lat = $urandom_range(0, 5);
      e   = model(st, f, a, lat);
      run_txn(st, f, a, lat, $urandom_range(2, 60), 0, o);
      n_checks++;
      if (o.timed_out || o.total !== e.total) begin n_fail++;
        $display("FAIL rnd%0d_cycles: got %0d want %0d (st=%0d f=%0d a=%h lat=%0d)", i, o.total, e.total, st, f, a, lat); end
      n_checks++;
      if (o.got_done !== e.is_done || o.got_fault !== !e.is_done || o.cause !== e.cause) begin n_fail++;
        $display("FAIL rnd%0d_outcome: got done=%0d cause=%0d want done=%0d cause=%0d", i, o.got_done, o.cause, e.is_done, e.cause); end
      n_checks++;
      if (o.req_n !== e.req_n || o.data_n !== e.data_n || o.addr_n !== 12) begin n_fail++;
        $display("FAIL rnd%0d_phase_len: got req=%0d data=%0d addr=%0d want %0d %0d 12", i, o.req_n, o.data_n, o.addr_n, e.req_n, e.data_n); end
      n_checks++;
      if (o.addr_err || o.data_err || o.busy_err || o.ser_func !== f) begin n_fail++;
        $display("FAIL rnd%0d_seq: got aerr=%0d derr=%0d berr=%0d func=%0d want 0 0 0 %0d", i, o.addr_err, o.data_err, o.busy_err, o.ser_func, f); end
      n_checks++;
      if (!o.idle1 || !o.idle2 || o.cause_after !== e.cause) begin n_fail++;
        $display("FAIL rnd%0d_after: got idle=%0d%0d cause=%0d want 11 cause=%0d", i, o.idle1, o.idle2, o.cause_after, e.cause); end
      if (e.req_n > 0) begin
        n_checks++;
        if (o.we !== st || (st && o.wstrb !== e.wstrb)) begin n_fail++;
          $display("FAIL rnd%0d_we_strb: got we=%0d strb=%b want we=%0d strb=%b", i, o.we, o.wstrb, st, e.wstrb); end
      end
    end
  endtask

  task automatic test_start_ignore();
    obs_t o;
    run_txn(0, 3'b010, 12'h100, 0, 5, 0, o);
    n_checks++;
    if (o.total !== 48 || o.addr_err || o.ser_func !== 3'b010) begin n_fail++;
      $display("FAIL ignore_in_addr: got cycles=%0d aerr=%0d func=%0d want 48 0 2", o.total, o.addr_err, o.ser_func); end
    run_txn(1, 3'b000, 12'h001, 0, 48, 0, o);
    n_checks++;
    if (o.total !== 48 || !o.got_done || !o.idle1 || !o.idle2) begin n_fail++;
      $display("FAIL ignore_in_done: got cycles=%0d done=%0d idle=%0d%0d want 48 1 11", o.total, o.got_done, o.idle1, o.idle2); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    run_txn(0, 3'b010, 12'h200, 1, 0, 30, o);
    n_checks++;
    if (!o.rst_hit || o.data_n !== 14 || o.rst_vec !== 21'd0) begin n_fail++;
      $display("FAIL reset_in_load_shift: got hit=%0d data_n=%0d outs=%h want 1 14 0", o.rst_hit, o.data_n, o.rst_vec); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_vec() !== 21'd0) begin n_fail++; $display("FAIL idle_after_mid_reset: got %h want 0", out_vec()); end
    run_txn(1, 3'b010, 12'h204, 1000, 0, 48, o);
    n_checks++;
    if (!o.rst_hit || o.req_n !== 2 || o.rst_vec !== 21'd0) begin n_fail++;
      $display("FAIL reset_in_store_req: got hit=%0d req_n=%0d outs=%h want 1 2 0", o.rst_hit, o.req_n, o.rst_vec); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignore();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Controls the bit-serial load/store datapath (Data_Serialiser) in the serial core.
- Accepts one memory request from the core control unit and steps the serialiser through three phases: address-shift, memory-handshake and data-shift.
- Checks alignment and func legality before any memory access is issued.
- Reports completion or a fault to the core.

Parameters:
- ADDR_BITS, 12, number of byte-address bits shifted into the serialiser (bit index 0..ADDR_BITS-1).
- DATA_BITS, 32, number of data bits shifted per access.
- TIMEOUT, 255, maximum cycles to wait for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  core request; sampled only in IDLE.
- is_store  in  1  1=store, 0=load; captured with start.
- req_func  in  3  RISC-V funct3; captured with start.
- busy  out  1  high in every state except IDLE.
- bit_valid  out  1  core must drive (addr/store) or sample (load) the serial bit this cycle.
- ser_mode  out  1  to serialiser mode: 1=address phase, 0=data phase.
- ser_bitpos  out  5  to serialiser bitPos.
- ser_func  out  3  to serialiser func; captured req_func.
- addr_bit  in  1  copy of the serial bit driven to the serialiser; used to capture addr[1:0].
- mem_req  out  1  memory request.
- mem_we  out  1  write enable, valid while mem_req is high.
- mem_wstrb  out  4  byte strobes, valid while mem_req && mem_we.
- mem_ack  in  1  memory acknowledge.
- done  out  1  one-cycle pulse: access completed.
- fault  out  1  one-cycle pulse: access aborted.
- fault_cause  out  2  valid with fault: 01 misaligned, 10 illegal func, 11 timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; all outputs 0, including ser_bitpos=0 and fault_cause=0.
  - mem_req drops immediately, including mid-access.
- Registered outputs: all outputs are registered Moore outputs.
- IDLE:
  - start=1 captures is_store and req_func, then goes to ADDR.
  - start in any other state is ignored; there is no queueing.
- ADDR:
  - Lasts ADDR_BITS cycles with ser_mode=1, bit_valid=1, ser_bitpos=0..ADDR_BITS-1.
  - addr_bit is captured when ser_bitpos=0 and when ser_bitpos=1.
- CHECK (1 cycle, bit_valid=0):
  - Illegal func (011, 110, 111) goes to FAULT with cause 10.
  - Else misaligned (func[1:0]=10 and addr[1:0]≠0, or func[1:0]=01 and addr[0]=1) goes to FAULT with cause 01.
  - Illegal func takes priority over misalignment.
  - Else a load goes to LOAD_REQ and a store goes to STORE_SHIFT.
- LOAD_REQ:
  - mem_req=1, mem_we=0 until mem_ack=1 is sampled, then LOAD_SHIFT.
  - Memory holds read data stable from ack until its next request.
- LOAD_SHIFT:
  - DATA_BITS cycles with ser_mode=0, bit_valid=1, ser_bitpos=0..31; the core samples the serial bit.
  - Then DONE.
- STORE_SHIFT:
  - 32 cycles with ser_mode=0, bit_valid=1, ser_bitpos=0..31; the core drives data bits.
  - Then STORE_REQ.
- STORE_REQ:
  - mem_req=1, mem_we=1 until mem_ack, then DONE.
  - mem_wstrb depends on func[1:0]:
    - byte (00): 0001 shifted left by addr[1:0].
    - half (01): addr[1] ? 1100 : 0011.
    - word (10): 1111.
- Timeout: in LOAD_REQ/STORE_REQ a wait counter clears on entry and increments each cycle without ack.
  - Reaching TIMEOUT goes to FAULT with cause 11.
  - mem_ack in the same cycle as expiry: ack wins.
- DONE / FAULT:
  - One cycle each; done or fault pulses high; fault_cause is held until the next start.
  - Then IDLE; a new start may be accepted on the IDLE cycle.
- mem_req never asserts on a faulting access.
- Counter: the bit counter is 6 bits, clears on phase entry and does not wrap within a phase.

Test Plan:
- Aligned LW, address 0x104, ack 2 cycles after req:
  - ADDR runs 12 cycles (bitpos 0..11, mode=1), then CHECK, then req held 3 cycles, then 32 shift cycles, then done.
  - done occurs 50 cycles after the start cycle.
- SH to 0x0A6:
  - After 32 store-shift cycles, mem_we=1 and mem_wstrb=1100; done is seen one cycle after ack.
- SB to addr[1:0]=11:
  - mem_wstrb=1000.
- LW to 0x102:
  - fault with cause 01 on the cycle after CHECK.
  - mem_req never rises; busy falls the next cycle.
- req_func=011:
  - fault with cause 10.
- TIMEOUT=4, load with mem_ack never asserted:
  - fault with cause 11 after 4 req cycles.
- Reset and start-ignore:
  - Assert rst_n=0 mid-LOAD_SHIFT: all outputs are 0 immediately.
  - start asserted during busy is ignored.
